// File: rtl/pd_log.sv
`default_nettype none
// ============================================================================
//  Module   : pd_log
//  Purpose  : Match-address logger for an upstream pattern detector. While
//             collecting, every flagged address is pushed into a small FIFO
//             that a consumer may drain at any time. Once the detector
//             reports it is finished the logger stops accepting matches,
//             waits for the FIFO to empty and then raises done.
//  Ports    : clk        - single clock, rising edge
//             rst_n      - synchronous active-low reset
//             flag       - match strobe, qualifies addr
//             addr[9:0]  - detector address (match address when flag=1)
//             fin        - detector finished (level)
//             out_valid  - head FIFO entry available
//             out_addr   - head FIFO entry, zero when empty
//             out_ready  - consumer accepts head entry
//             match_cnt  - saturating count of flagged matches
//             overflow   - sticky: a match was dropped on a full FIFO
//             done       - finished and fully drained
//  Params   : DEPTH      - FIFO depth, power of two in 2..64
//  Revision : 1.0 - initial release
// ============================================================================
module pd_log #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flag,
    input  logic [9:0] addr,
    input  logic       fin,
    output logic       out_valid,
    output logic [9:0] out_addr,
    input  logic       out_ready,
    output logic [9:0] match_cnt,
    output logic       overflow,
    output logic       done
);

    localparam int                  c_PTR_W   = $clog2(DEPTH);
    localparam int                  c_OCC_W   = c_PTR_W + 1;
    localparam logic [c_OCC_W-1:0]  c_FULL    = c_OCC_W'(DEPTH);
    localparam logic [9:0]          c_CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Registered state
    state_t               r_state_q;
    logic [c_PTR_W-1:0]   r_wr_ptr_q;
    logic [c_PTR_W-1:0]   r_rd_ptr_q;
    logic [c_OCC_W-1:0]   r_occ_q;
    logic [9:0]           r_cnt_q;
    logic                 r_ovf_q;
    logic [9:0]           r_mem [DEPTH];

    // Next-state values
    state_t               w_state_d;
    logic [c_PTR_W-1:0]   w_wr_ptr_d;
    logic [c_PTR_W-1:0]   w_rd_ptr_d;
    logic [c_OCC_W-1:0]   w_occ_d;
    logic [9:0]           w_cnt_d;
    logic                 w_ovf_d;

    // Per-edge events
    logic                 w_not_empty;
    logic                 w_full;
    logic                 w_match;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    always_comb begin
        w_not_empty = (r_occ_q != '0);
        w_full      = (r_occ_q == c_FULL);
        // Matches only count while collecting; the pop is gated by the
        // registered occupancy so out_ready is ignored on an empty FIFO.
        w_match     = (r_state_q == ST_COLLECT) && flag;
        w_pop       = w_not_empty && out_ready;
        // A full FIFO still accepts a push if the head leaves on the same edge.
        w_push      = w_match && (!w_full || w_pop);
        w_drop      = w_match && w_full && !w_pop;
    end

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_occ_d    = r_occ_q;
        w_cnt_d    = r_cnt_q;
        w_ovf_d    = r_ovf_q | w_drop;
        w_state_d  = r_state_q;

        // Pointers wrap naturally since DEPTH is a power of two.
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   w_occ_d = r_occ_q + c_OCC_W'(1);
            2'b01:   w_occ_d = r_occ_q - c_OCC_W'(1);
            default: w_occ_d = r_occ_q;
        endcase

        // Dropped matches are still counted.
        if (w_match && (r_cnt_q != c_CNT_MAX)) begin
            w_cnt_d = r_cnt_q + 10'd1;
        end

        case (r_state_q)
            ST_COLLECT: begin
                if (fin) begin
                    w_state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_not_empty) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_d = ST_DONE;
            end
            default: begin
                w_state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q  <= ST_COLLECT;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_occ_q    <= '0;
            r_cnt_q    <= '0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_occ_q    <= w_occ_d;
            r_cnt_q    <= w_cnt_d;
            r_ovf_q    <= w_ovf_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the occupancy counter
    // and out_addr is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr_q] <= addr;
        end
    end

    assign out_valid = w_not_empty;
    assign out_addr  = w_not_empty ? r_mem[r_rd_ptr_q] : 10'd0;
    assign match_cnt = r_cnt_q;
    assign overflow  = r_ovf_q;
    assign done      = (r_state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pd_log.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pd_log
//  Purpose  : Self-checking bench for pd_log. A queue-based reference model
//             predicts FIFO contents, counters and completion; predicted
//             pops are pushed to a scoreboard queue that a separate monitor
//             drains whenever the DUT hands over an entry.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pd_log;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag;
    logic [9:0] addr;
    logic       fin;
    logic       out_valid;
    logic [9:0] out_addr;
    logic       out_ready;
    logic [9:0] match_cnt;
    logic       overflow;
    logic       done;

    pd_log #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flag      (flag),
        .addr      (addr),
        .fin       (fin),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_ready (out_ready),
        .match_cnt (match_cnt),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model state (reflects the DUT after the most recent edge
    // once step() has applied the next edge's rules)
    logic [9:0] m_fifo [$];
    int         m_cnt      = 0;
    bit         m_ovf      = 1'b0;
    bit         m_fin_seen = 1'b0;
    bit         m_done     = 1'b0;

    // Scoreboard of expected handed-over addresses
    logic [9:0] exp_q [$];

    // Snapshot of what the DUT should show during the current cycle
    int         cur_occ  = 0;
    logic [9:0] cur_head = 10'd0;
    int         cur_cnt  = 0;
    bit         cur_ovf  = 1'b0;
    bit         cur_done = 1'b0;
    bit         checking = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by one edge, wait for it.
    task automatic step(input bit f, input logic [9:0] a, input bit fi,
                        input bit rdy, input bit rn);
        int pre;
        bit pop;
        flag      = f;
        addr      = a;
        fin       = fi;
        out_ready = rdy;
        rst_n     = rn;

        cur_occ  = m_fifo.size();
        cur_head = (m_fifo.size() > 0) ? m_fifo[0] : 10'd0;
        cur_cnt  = m_cnt;
        cur_ovf  = m_ovf;
        cur_done = m_done;

        if (!rn) begin
            m_fifo.delete();
            m_cnt      = 0;
            m_ovf      = 1'b0;
            m_fin_seen = 1'b0;
            m_done     = 1'b0;
        end else begin
            pre = m_fifo.size();
            pop = (pre > 0) && rdy;
            if (pop) exp_q.push_back(m_fifo.pop_front());
            if (!m_fin_seen && f) begin
                if (m_cnt < 1023) m_cnt++;
                if (m_fifo.size() < DEPTH) m_fifo.push_back(a);
                else                       m_ovf = 1'b1;
            end
            if (!m_fin_seen) begin
                if (fi) m_fin_seen = 1'b1;
            end else if (pre == 0) begin
                m_done = 1'b1;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain_all();
        repeat (DEPTH + 4) step(1'b0, 10'd0, 1'b1, 1'b1, 1'b1);
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("out_valid", out_valid, cur_occ > 0);
            chk("match_cnt", match_cnt, cur_cnt);
            chk("overflow",  overflow,  cur_ovf);
            chk("done",      done,      cur_done);
            if (cur_occ > 0) chk("head_addr", out_addr, cur_head);
            else             chk("idle_addr", out_addr, 10'd0);
            if (out_valid && out_ready && rst_n) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    chk("pop_order", out_addr, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit fin_lvl;
        bit rn;
        int n;
        int rdy_pct;
        rst_n = 1'b0; flag = 1'b0; fin = 1'b0; addr = 10'd0; out_ready = 1'b0;

        // Reset held two edges with flag and fin active
        step(1'b1, 10'h3ff, 1'b1, 1'b1, 1'b0);
        step(1'b1, 10'h3ff, 1'b1, 1'b1, 1'b0);
        checking = 1'b1;
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);

        // Basic log of three addresses then drain
        step(1'b1, 10'd5,  1'b0, 1'b0, 1'b1);
        step(1'b1, 10'd9,  1'b0, 1'b0, 1'b1);
        step(1'b1, 10'd20, 1'b0, 1'b0, 1'b1);
        step(1'b0, 10'd0,  1'b1, 1'b0, 1'b1);
        repeat (6) step(1'b0, 10'd0, 1'b1, 1'b1, 1'b1);
        do_reset();

        // Overflow: 18 matches into a 16-deep FIFO
        for (int i = 0; i < 18; i++) step(1'b1, 10'(100 + i * 3), 1'b0, 1'b0, 1'b1);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b1);
        drain_all();
        do_reset();

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(1'b1, 10'(200 + i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 10'd777, 1'b0, 1'b1, 1'b1);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b1);
        drain_all();
        do_reset();

        // Finish with nothing logged; flag alongside fin is still a match
        repeat (3) step(1'b0, 10'd0, 1'b1, 1'b1, 1'b1);
        do_reset();
        step(1'b1, 10'd321, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b1, 10'd55, 1'b1, 1'b1, 1'b1);
        do_reset();

        // Reset in the middle of draining
        for (int i = 0; i < 4; i++) step(1'b1, 10'(40 + i), 1'b0, 1'b0, 1'b1);
        step(1'b0, 10'd0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 10'd0, 1'b1, 1'b1, 1'b1);
        do_reset();
        step(1'b1, 10'd7, 1'b0, 1'b0, 1'b1);
        step(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
        drain_all();
        do_reset();

        // Counter saturation
        repeat (1100) step(1'b1, 10'($urandom), 1'b0, 1'($urandom), 1'b1);
        drain_all();
        do_reset();

        // Randomized rounds with occasional reset
        repeat (10) begin
            n       = $urandom_range(20, 250);
            rdy_pct = $urandom_range(5, 95);
            fin_lvl = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (!fin_lvl && $urandom_range(0, 59) == 0) fin_lvl = 1'b1;
                rn = ($urandom_range(0, 149) != 0);
                step(1'($urandom), 10'($urandom), fin_lvl,
                     $urandom_range(0, 99) < rdy_pct, rn);
                if (!rn) fin_lvl = 1'b0;
            end
            drain_all();
            do_reset();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
